// File: rtl/rf_op_sequencer.sv
// Sequences three-address operations (read two sources, run the ALU, write the result)
// and clear-all commands onto a 16-entry register file.
module rf_op_sequencer #(
    parameter int DATA_W      = 16,
    parameter int EXEC_CYCLES = 2,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_clr,
    input  logic [3:0]         req_dst,
    input  logic [3:0]         req_srca,
    input  logic [3:0]         req_srcb,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               alu_start,
    output logic [3:0]         rf_Aaddr,
    output logic [3:0]         rf_Baddr,
    output logic [3:0]         rf_Caddr,
    output logic [DATA_W-1:0]  rf_C,
    output logic               rf_load,
    output logic               rf_clear_n,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_CLR   = 3'd4
    } state_t;

    localparam logic [3:0]         EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [3:0] dst;
    logic [3:0] exec_cnt;

    // Only IDLE accepts, and an asserted clear blocks acceptance in the same cycle.
    assign req_ready = (state == S_IDLE) && !clear;

    // Control FSM; rf_C doubles as the result register, rf_Aaddr/rf_Baddr as the latched sources.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state      <= S_IDLE;
            dst        <= 4'd0;
            exec_cnt   <= 4'd0;
            rf_Aaddr   <= 4'd0;
            rf_Baddr   <= 4'd0;
            rf_Caddr   <= 4'd0;
            rf_C       <= '0;
            rf_load    <= 1'b1;
            rf_clear_n <= 1'b1;
            alu_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            op_count   <= '0;
        end else begin
            alu_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        dst  <= req_dst;
                        busy <= 1'b1;
                        if (req_clr) begin
                            state      <= S_CLR;
                            rf_clear_n <= 1'b0;
                        end else begin
                            state    <= S_READ;
                            rf_Aaddr <= req_srca;
                            rf_Baddr <= req_srcb;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_READ: begin
                    state     <= S_EXEC;
                    alu_start <= 1'b1;
                    exec_cnt  <= 4'd0;
                end
                S_EXEC: begin
                    if (exec_cnt == EXEC_LAST) begin
                        state    <= S_WRITE;
                        rf_C     <= alu_result;
                        rf_Caddr <= dst;
                        rf_load  <= 1'b0;
                    end else begin
                        exec_cnt <= exec_cnt + 4'd1;
                    end
                end
                S_WRITE: begin
                    state    <= S_IDLE;
                    rf_load  <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    op_count <= op_count + COUNT_ONE;
                end
                S_CLR: begin
                    state      <= S_IDLE;
                    rf_clear_n <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    op_count   <= op_count + COUNT_ONE;
                end
                default: begin
                    state      <= S_IDLE;
                    rf_load    <= 1'b1;
                    rf_clear_n <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Randomised scoreboard bench for rf_op_sequencer with register-file and ALU models.
module tb_rf_op_sequencer;
    localparam int DW  = 16;
    localparam int EXC = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_clr = 1'b0;
    logic [3:0]    req_dst = 4'd0;
    logic [3:0]    req_srca = 4'd0;
    logic [3:0]    req_srcb = 4'd0;
    logic [DW-1:0] alu_result;
    logic          alu_start;
    logic [3:0]    rf_Aaddr, rf_Baddr, rf_Caddr;
    logic [DW-1:0] rf_C;
    logic          rf_load, rf_clear_n, busy, done;
    logic [CW-1:0] op_count;

    rf_op_sequencer #(.DATA_W(DW), .EXEC_CYCLES(EXC), .COUNT_W(CW)) dut (
        .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_clr(req_clr), .req_dst(req_dst), .req_srca(req_srca), .req_srcb(req_srcb),
        .alu_result(alu_result), .alu_start(alu_start), .rf_Aaddr(rf_Aaddr),
        .rf_Baddr(rf_Baddr), .rf_Caddr(rf_Caddr), .rf_C(rf_C), .rf_load(rf_load),
        .rf_clear_n(rf_clear_n), .busy(busy), .done(done), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_clr;
        logic [3:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] count_q[$];
    logic [DW-1:0] ref_regs [16];
    logic [CW-1:0] exp_count = '0;
    int            total = 0;
    int            passed = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            clr_cnt = 0;
    logic          pend = 1'b0;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] init_val [16];
    logic          init_rf = 1'b1;
    logic [DW-1:0] ra = '0;
    logic [DW-1:0] rb = '0;
    logic [DW-1:0] alu_hold = '0;

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a ^ {b[7:0], b[15:8]}) + 16'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: clear beats write beats read.
    always @(posedge clk) begin
        if (init_rf) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val[i];
        end else if (!rf_clear_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (!rf_load) begin
            mem[rf_Caddr] <= rf_C;
        end else begin
            ra <= mem[rf_Aaddr];
            rb <= mem[rf_Baddr];
        end
    end

    // ALU model: computes on alu_start, scrambles its output after each completion.
    always @(posedge clk) begin
        if (alu_start) alu_hold <= alu_f(ra, rb);
        else if (done) alu_hold <= DW'($urandom);
    end
    assign alu_result = alu_hold;

    // Monitor: pops expected register-file commands and completion counts.
    always @(negedge clk) begin
        exp_t e;
        if (clear) begin
            pend = 1'b0;
        end else begin
            check("done_pulse", 32'(done), 32'(pend));
            if (pend) begin
                check("count_avail", 32'(count_q.size() != 0), 32'd1);
                if (count_q.size() != 0) check("op_count", 32'(op_count), 32'(count_q.pop_front()));
            end
            pend = 1'b0;
            if (!rf_load || !rf_clear_n) begin
                check("rf_cmd_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (!rf_clear_n) begin
                        check("clr_kind", 32'(e.is_clr), 32'd1);
                        check("clr_load_high", 32'(rf_load), 32'd1);
                        clr_cnt++;
                    end else begin
                        check("wr_kind", 32'(e.is_clr), 32'd0);
                        check("wr_addr", 32'(rf_Caddr), 32'(e.addr));
                        check("wr_data", 32'(rf_C), 32'(e.data));
                        wr_cnt++;
                    end
                end
                pend = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic c, input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        if (c) begin
            for (int i = 0; i < 16; i++) ref_regs[i] = '0;
            e.is_clr = 1'b1; e.addr = 4'd0; e.data = '0;
        end else begin
            e.is_clr = 1'b0; e.addr = d; e.data = alu_f(ref_regs[a], ref_regs[b]);
            ref_regs[d] = e.data;
        end
        exp_q.push_back(e);
        exp_count = exp_count + 4'd1;
        count_q.push_back(exp_count);
    endtask

    task automatic do_op(input logic c, input logic [3:0] d, input logic [3:0] a,
                         input logic [3:0] b, input logic track, output int acc);
        int n = 0;
        req_clr = c; req_dst = d; req_srca = a; req_srcb = b; req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_timeout", 32'(n < 100), 32'd1);
        acc = cyc;
        if (track) model(c, d, a, b);
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || count_q.size() != 0 || busy || pend) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n < 200), 32'd1);
        tick();
    endtask

    initial begin
        int a1, a2, a3, w0, c0;
        logic [3:0] d, a, b;
        for (int i = 0; i < 16; i++) begin
            init_val[i] = DW'($urandom);
            ref_regs[i] = init_val[i];
        end
        tick(); tick();
        init_rf = 1'b0;
        check("rst_rf_load", 32'(rf_load), 32'd1);
        check("rst_rf_clear_n", 32'(rf_clear_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        clear = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        tick();

        // Single operation with cycle-accurate control checks.
        do_op(1'b0, 4'd3, 4'd1, 4'd2, 1'b1, a1);
        req_valid = 1'b0;
        check("c1_Aaddr", 32'(rf_Aaddr), 32'd1);
        check("c1_Baddr", 32'(rf_Baddr), 32'd2);
        check("c1_alu_start", 32'(alu_start), 32'd0);
        check("c1_ready", 32'(req_ready), 32'd0);
        tick();
        check("c2_alu_start", 32'(alu_start), 32'd1);
        tick();
        check("c3_alu_start", 32'(alu_start), 32'd0);
        tick();
        check("c4_rf_load", 32'(rf_load), 32'd0);
        check("c4_Caddr", 32'(rf_Caddr), 32'd3);
        check("c4_rf_C", 32'(rf_C), 32'(ref_regs[3]));
        tick();
        check("c5_done", 32'(done), 32'd1);
        check("c5_ready", 32'(req_ready), 32'd1);
        check("c5_busy", 32'(busy), 32'd0);
        wait_idle();

        // Back-to-back operations with valid held.
        w0 = wr_cnt;
        do_op(1'b0, 4'd7, 4'd3, 4'd9, 1'b1, a1);
        do_op(1'b0, 4'd9, 4'd7, 4'd7, 1'b1, a2);
        do_op(1'b0, 4'd2, 4'd9, 4'd3, 1'b1, a3);
        req_valid = 1'b0;
        wait_idle();
        check("b2b_gap1", 32'(a2 - a1), 32'(EXC + 3));
        check("b2b_gap2", 32'(a3 - a2), 32'(EXC + 3));
        check("b2b_writes", 32'(wr_cnt - w0), 32'd3);

        // Back-to-back clear-all commands.
        w0 = wr_cnt; c0 = clr_cnt;
        do_op(1'b1, 4'd4, 4'd5, 4'd6, 1'b1, a1);
        do_op(1'b1, 4'd1, 4'd1, 4'd1, 1'b1, a2);
        req_valid = 1'b0;
        wait_idle();
        check("clr_gap", 32'(a2 - a1), 32'd2);
        check("clr_count", 32'(clr_cnt - c0), 32'd2);
        check("clr_no_write", 32'(wr_cnt - w0), 32'd0);

        // Reset asserted during EXEC aborts the operation.
        w0 = wr_cnt;
        do_op(1'b0, 4'd6, 4'd1, 4'd2, 1'b0, a1);
        req_valid = 1'b0;
        tick(); tick();
        clear = 1'b1;
        #1;
        check("abort_rf_load", 32'(rf_load), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_op_count", 32'(op_count), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        exp_count = '0;
        tick();
        clear = 1'b0;
        tick(); tick(); tick(); tick();
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_no_write", 32'(wr_cnt - w0), 32'd0);
        check("abort_count_held", 32'(op_count), 32'd0);
        do_op(1'b0, 4'd8, 4'd2, 4'd7, 1'b1, a1);
        req_valid = 1'b0;
        wait_idle();

        // dst equal to source: register 5 counts up from zero through the ALU.
        do_op(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, a1);
        for (int k = 0; k < 8; k++) do_op(1'b0, 4'd5, 4'd5, 4'd0, 1'b1, a1);
        req_valid = 1'b0;
        wait_idle();
        check("dst_eq_src_reg5", 32'(mem[5]), 32'h0000_0008);

        // Randomised operations and clears with random gaps.
        for (int k = 0; k < 40; k++) begin
            d = 4'($urandom); a = 4'($urandom); b = 4'($urandom);
            if ($urandom_range(0, 3) == 0) a = d;
            do_op(($urandom_range(0, 7) == 0), d, a, b, 1'b1, a1);
            if ($urandom_range(0, 1) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 6)) tick();
            end
        end
        req_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 16; i++) check("final_reg", 32'(mem[i]), 32'(ref_regs[i]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
